dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
Parametrised N-requester arbiter for one port of the dual-port data memory. It generalises the current fixed CPU-over-VGA address mux on port A.
- Serialises CPU, VGA-reader and future accelerator accesses onto a single RAM port.
- Supports fixed-priority or round-robin arbitration, with starvation protection in fixed mode.
- Returns read data to the correct requester after the RAM's read latency.

Parameters:
NUM_REQ, 3, number of requesters; index 0 is highest priority in fixed mode.
ADDR_W, 16, RAM address width; narrower requester addresses are zero-extended by the instantiator.
DATA_W, 16, RAM data width.
RD_LATENCY, 1, cycles from ram_rden to valid ram_q; legal range 1..4.
RR_MODE, 0, 0 = fixed priority with anti-starvation, 1 = round-robin.
STARVE_LIMIT, 8, fixed mode only: number of consecutive lost cycles after which a requester is forced to win.

Ports:
clk  in  1  system clock (CLOCK_50 domain)
rst_n  in  1  reset; one clock; asynchronous, active-low
req_ren  in  NUM_REQ  per-requester read request
req_wren  in  NUM_REQ  per-requester write request
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_gnt  out  NUM_REQ  one-hot grant, same cycle as the request
rd_valid  out  NUM_REQ  one-hot; read data valid for that requester
rd_data  out  DATA_W  shared read-return data
ram_addr  out  ADDR_W  to RAM address
ram_data  out  DATA_W  to RAM write data
ram_rden  out  1  RAM read enable
ram_wren  out  1  RAM write enable
ram_q  in  DATA_W  RAM read data

Behaviour:
- Request handling
  - A requester is active when req_ren[i] | req_wren[i].
  - If both ren and wren are set, the access is a write; no rd_valid is produced.
  - A requester holds addr/data/request stable until it sees req_gnt[i]; it may drop the request after the grant cycle.
- Grant
  - Grant is combinational from the requests and registered arbitration state. At most one bit is set. Zero bits are set when no requests are active.
  - ram_addr, ram_data, ram_rden and ram_wren are driven combinationally from the granted requester.
  - With no grant: ram_rden = ram_wren = 0, ram_addr = 0, ram_data = 0.
- Fixed mode (RR_MODE = 0)
  - The lowest-index active requester wins.
  - Each requester keeps a wait counter:
    - increments on each cycle it is active but not granted, saturating at STARVE_LIMIT;
    - clears on grant, or when the requester is inactive.
  - Any requester whose counter equals STARVE_LIMIT overrides priority. If several are starved, the lowest index among them wins.
- Round-robin mode (RR_MODE = 1)
  - A pointer ptr (reset 0) marks the highest-priority index.
  - The search runs ptr, ptr+1, … with wrap-around modulo NUM_REQ.
  - After any grant to index g, ptr <= (g+1) mod NUM_REQ. ptr is unchanged on idle cycles.
- Read return
  - A shift register of depth RD_LATENCY carries {valid, one-hot id} for each granted read.
  - rd_valid = tail valid ? tail id : 0.
  - rd_data = ram_q, passed combinationally; it is only meaningful while rd_valid is non-zero.
  - Back-to-back reads give one rd_valid per cycle, in grant order, with no bubbles.
- Reset
  - Asynchronous assertion clears: all wait counters, ptr, and the return pipeline.
  - All outputs read 0 while rst_n = 0, including req_gnt.
  - A reset mid-operation drops in-flight reads: no rd_valid appears after deassertion for reads granted before reset.
- Throughput and latency
  - One access per cycle.
  - Grant latency is 0 cycles when uncontested.
  - Read data arrives exactly RD_LATENCY cycles after the grant cycle.

Decomposition:
- Package dmem_arb_pkg holds:
  - localparam requester index constants REQ_CPU = 0, REQ_VGA = 1, REQ_ACC = 2;
  - function onehot_to_idx;
  - function rr_pick (rotate, priority-encode, unrotate).
- One sub-module, dmem_rd_tag_pipe: the RD_LATENCY-deep {valid, id} shift register with async clear.

Test Plan:
1. RR_MODE = 0, RD_LATENCY = 1. Requester 1 reads addr 0x0040 (ram_q model returns 0xBEEF); requester 0 is idle.
   Required: req_gnt = 3'b010 in the same cycle; next cycle rd_valid = 3'b010, rd_data = 0xBEEF.
2. RR_MODE = 0, STARVE_LIMIT = 8. Requesters 0 and 1 request continuously.
   Required: requester 0 is granted for cycles 0–7; cycle 8 grants requester 1 (counter = 8); cycle 9 grants requester 0 again.
3. RR_MODE = 1. All three requesters request continuously.
   Required: grant sequence 001, 010, 100, 001, …; ptr wraps from 2 to 0.
4. RD_LATENCY = 3. Reads from requesters 0, 2, 1 on consecutive cycles.
   Required: rd_valid = 001, 100, 010 on cycles 3, 4, 5 respectively, each with matching ram_q.
5. Requester 2 asserts ren and wren together, addr 0x0010, wdata 0x1234.
   Required: ram_wren = 1, ram_rden = 0, ram_data = 0x1234; no rd_valid follows.
6. RD_LATENCY = 2. Read granted, then rst_n pulsed low for 1 cycle before the data returns.
   Required: req_gnt and rd_valid are 0 during reset; no rd_valid ever appears for that read; ptr and counters are 0 after reset.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared constants and selection helpers for the data-memory port arbiter.
// Helpers work on a fixed MAX_REQ-wide vector; callers zero-extend their requests.
package dmem_arb_pkg;

    localparam int REQ_CPU = 0;
    localparam int REQ_VGA = 1;
    localparam int REQ_ACC = 2;

    localparam int MAX_REQ = 16;
    localparam int IDX_W   = 4;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

    // Rotate so ptr sits at bit 0, keep the lowest set bit, rotate back.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input logic [IDX_W-1:0]   ptr,
                                                   input int                 n);
        logic [MAX_REQ-1:0] rot;
        logic [MAX_REQ-1:0] first;
        logic [MAX_REQ-1:0] gnt;
        int                 pos;
        rot = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                pos = int'(ptr) + k;
                if (pos >= n) pos = pos - n;
                rot[k] = req[pos];
            end
        end
        first = rot & (-rot);
        gnt   = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                pos = int'(ptr) + k;
                if (pos >= n) pos = pos - n;
                gnt[pos] = first[k];
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/dmem_rd_tag_pipe.sv
// Carries {valid, one-hot requester id} for each granted read until the RAM
// returns its data RD_LATENCY cycles later.
module dmem_rd_tag_pipe #(
    parameter int NUM_REQ    = 3,
    parameter int RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_vld,
    input  logic [NUM_REQ-1:0] in_id,
    output logic               out_vld,
    output logic [NUM_REQ-1:0] out_id
);

    logic               vld_p [RD_LATENCY];
    logic [NUM_REQ-1:0] id_p  [RD_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RD_LATENCY; k++) vld_p[k] <= 1'b0;
        end else begin
            vld_p[0] <= in_vld;
            for (int k = 1; k < RD_LATENCY; k++) vld_p[k] <= vld_p[k-1];
        end
    end

    // The id is only looked at while its valid bit is set, so it needs no reset.
    always_ff @(posedge clk) begin
        id_p[0] <= in_id;
        for (int k = 1; k < RD_LATENCY; k++) id_p[k] <= id_p[k-1];
    end

    assign out_vld = vld_p[RD_LATENCY-1];
    assign out_id  = id_p[RD_LATENCY-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// N-requester arbiter serialising CPU, VGA and accelerator accesses onto one
// data-memory port, with read data steered back to the requester that asked.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int RD_LATENCY   = 1,
    parameter int RR_MODE      = 0,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_ren,
    input  logic [NUM_REQ-1:0]        req_wren,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_gnt,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_data,
    output logic                      ram_rden,
    output logic                      ram_wren,
    input  logic [DATA_W-1:0]         ram_q
);

    logic [NUM_REQ-1:0] active;
    logic [NUM_REQ-1:0] gnt_raw;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               tail_vld;
    logic [NUM_REQ-1:0] tail_id;

    assign active  = req_ren | req_wren;
    // Grant is forced low while reset is held so no access leaks to the RAM.
    assign gnt     = rst_n ? gnt_raw : '0;
    assign gnt_idx = onehot_to_idx(MAX_REQ'(gnt));

    generate
        if (RR_MODE == 0) begin : g_fixed
            localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

            logic [CNT_W-1:0]   wait_cnt [NUM_REQ];
            logic [NUM_REQ-1:0] starved;

            always_comb begin
                starved = '0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    starved[i] = active[i] && (wait_cnt[i] == CNT_W'(STARVE_LIMIT));
                end
            end

            // Starved requesters pre-empt normal priority; lowest index wins in each group.
            assign gnt_raw = (|starved) ? (starved & (-starved)) : (active & (-active));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
                end else begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (active[i] && !gnt[i]) begin
                            if (wait_cnt[i] != CNT_W'(STARVE_LIMIT)) begin
                                wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
                            end
                        end else begin
                            wait_cnt[i] <= '0;
                        end
                    end
                end
            end
        end else begin : g_rr
            localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

            logic [PTR_W-1:0]   ptr;
            logic [MAX_REQ-1:0] pick_full;
            logic               pick_unused;

            assign pick_full   = rr_pick(MAX_REQ'(active), IDX_W'(ptr), NUM_REQ);
            assign gnt_raw     = pick_full[NUM_REQ-1:0];
            assign pick_unused = ^pick_full;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ptr <= '0;
                end else if (|gnt) begin
                    ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : PTR_W'(gnt_idx + IDX_W'(1));
                end
            end
        end
    endgenerate

    // Stage p0: drive the RAM port from the granted requester.
    always_comb begin
        ram_addr = '0;
        ram_data = '0;
        if (|gnt) begin
            ram_addr = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
            ram_data = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
        end
    end

    // A request with both enables set is a write and never produces read data.
    assign ram_rden = |(gnt & req_ren & ~req_wren);
    assign ram_wren = |(gnt & req_wren);
    assign req_gnt  = gnt;

    // Stage p1..pN: read tags travel alongside the RAM's own latency.
    dmem_rd_tag_pipe #(
        .NUM_REQ   (NUM_REQ),
        .RD_LATENCY(RD_LATENCY)
    ) u_tag_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_vld (ram_rden),
        .in_id  (gnt),
        .out_vld(tail_vld),
        .out_id (tail_id)
    );

    assign rd_valid = tail_vld ? tail_id : '0;
    assign rd_data  = rst_n ? ram_q : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: three instances (fixed/lat1, round-robin/lat3,
// fixed/lat2) driven by directed and random traffic against a behavioural model.
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    localparam int N     = 3;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int LIMIT = 8;
    localparam int ND    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic [N-1:0]    ren      [ND];
    logic [N-1:0]    wren     [ND];
    logic [N*AW-1:0] addr     [ND];
    logic [N*DW-1:0] wdata    [ND];
    logic [N-1:0]    gnt      [ND];
    logic [N-1:0]    rd_valid [ND];
    logic [DW-1:0]   rd_data  [ND];
    logic [AW-1:0]   ram_addr [ND];
    logic [DW-1:0]   ram_data [ND];
    logic            ram_rden [ND];
    logic            ram_wren [ND];
    logic [DW-1:0]   ram_q    [ND];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            cnt      [ND][N];
    int            ptr      [ND];
    logic [N-1:0]  pend     [ND][5];
    logic [DW-1:0] pend_d   [ND][5];
    logic [N-1:0]  last_gnt [ND];
    bit            busy     [ND][N];

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 2);
    endfunction

    function automatic bit rr_of(int d);
        return (d == 1);
    endfunction

    function automatic logic [DW-1:0] ram_val(logic [AW-1:0] a);
        if (a == 16'h0040) return 16'hBEEF;
        return (a * 16'd7) ^ 16'h1357;
    endfunction

    generate
        for (genvar d = 0; d < ND; d++) begin : g_dut
            logic [DW-1:0] rq [4];

            dmem_port_arbiter #(
                .NUM_REQ     (N),
                .ADDR_W      (AW),
                .DATA_W      (DW),
                .RD_LATENCY  ((d == 0) ? 1 : ((d == 1) ? 3 : 2)),
                .RR_MODE     ((d == 1) ? 1 : 0),
                .STARVE_LIMIT(LIMIT)
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .req_ren  (ren[d]),
                .req_wren (wren[d]),
                .req_addr (addr[d]),
                .req_wdata(wdata[d]),
                .req_gnt  (gnt[d]),
                .rd_valid (rd_valid[d]),
                .rd_data  (rd_data[d]),
                .ram_addr (ram_addr[d]),
                .ram_data (ram_data[d]),
                .ram_rden (ram_rden[d]),
                .ram_wren (ram_wren[d]),
                .ram_q    (ram_q[d])
            );

            // RAM with a fixed read latency; contents are a function of the address.
            always @(posedge clk) begin
                rq[0] <= ram_rden[d] ? ram_val(ram_addr[d]) : 16'h0000;
                for (int k = 1; k < 4; k++) rq[k] <= rq[k-1];
            end
            assign ram_q[d] = rq[((d == 0) ? 1 : ((d == 1) ? 3 : 2)) - 1];
        end
    endgenerate

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_pick(int d);
        logic [N-1:0] act;
        int           i;
        act = ren[d] | wren[d];
        if (!rst_n) return '0;
        if (rr_of(d)) begin
            for (int k = 0; k < N; k++) begin
                i = (ptr[d] + k) % N;
                if (act[i]) return N'(1 << i);
            end
            return '0;
        end
        for (int j = 0; j < N; j++) if (act[j] && cnt[d][j] == LIMIT) return N'(1 << j);
        for (int j = 0; j < N; j++) if (act[j]) return N'(1 << j);
        return '0;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < ND; d++) begin
            ptr[d]      = 0;
            last_gnt[d] = '0;
            for (int i = 0; i < N; i++) cnt[d][i] = 0;
            for (int k = 0; k < 5; k++) begin
                pend[d][k]   = '0;
                pend_d[d][k] = '0;
            end
        end
    endtask

    // Called right after inputs are set on the falling edge.
    task automatic check_cycle();
        #1;
        for (int d = 0; d < ND; d++) begin
            logic [N-1:0]  eg;
            logic [N-1:0]  act;
            logic [N-1:0]  ev;
            logic          e_rd, e_wr;
            logic [AW-1:0] e_addr;
            logic [DW-1:0] e_data;
            int            g;
            eg     = model_pick(d);
            act    = ren[d] | wren[d];
            g      = -1;
            e_rd   = 1'b0;
            e_wr   = 1'b0;
            e_addr = '0;
            e_data = '0;
            for (int i = 0; i < N; i++) if (eg[i]) g = i;
            if (g >= 0) begin
                e_rd   = ren[d][g] && !wren[d][g];
                e_wr   = wren[d][g];
                e_addr = addr[d][g*AW +: AW];
                e_data = wdata[d][g*DW +: DW];
            end
            ev = rst_n ? pend[d][0] : '0;
            check($sformatf("gnt%0d", d), 64'(gnt[d]), 64'(eg));
            check($sformatf("ram_addr%0d", d), 64'(ram_addr[d]), 64'(e_addr));
            check($sformatf("ram_data%0d", d), 64'(ram_data[d]), 64'(e_data));
            check($sformatf("ram_en%0d", d), 64'({ram_rden[d], ram_wren[d]}), 64'({e_rd, e_wr}));
            check($sformatf("rd_valid%0d", d), 64'(rd_valid[d]), 64'(ev));
            if (!rst_n)
                check($sformatf("rd_data_rst%0d", d), 64'(rd_data[d]), 64'(0));
            else if (ev != '0)
                check($sformatf("rd_data%0d", d), 64'(rd_data[d]), 64'(pend_d[d][0]));

            if (!rst_n) begin
                ptr[d] = 0;
                for (int i = 0; i < N; i++) cnt[d][i] = 0;
                for (int k = 0; k < 5; k++) pend[d][k] = '0;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    pend[d][k]   = pend[d][k+1];
                    pend_d[d][k] = pend_d[d][k+1];
                end
                pend[d][4] = '0;
                if (e_rd) begin
                    pend[d][lat_of(d)-1]   = eg;
                    pend_d[d][lat_of(d)-1] = ram_val(e_addr);
                end
                for (int i = 0; i < N; i++) begin
                    if (act[i] && !eg[i]) cnt[d][i] = (cnt[d][i] < LIMIT) ? cnt[d][i] + 1 : LIMIT;
                    else cnt[d][i] = 0;
                end
                if (g >= 0) ptr[d] = (g + 1) % N;
            end
            last_gnt[d] = eg;
        end
    endtask

    task automatic idle_all();
        for (int d = 0; d < ND; d++) begin
            ren[d]   = '0;
            wren[d]  = '0;
            addr[d]  = '0;
            wdata[d] = '0;
        end
    endtask

    task automatic set_all(input int i, input bit r, input bit w,
                           input logic [AW-1:0] a, input logic [DW-1:0] dd);
        for (int d = 0; d < ND; d++) begin
            ren[d][i]             = r;
            wren[d][i]            = w;
            addr[d][i*AW +: AW]   = a;
            wdata[d][i*DW +: DW]  = dd;
        end
    endtask

    task automatic gen_random();
        int kind;
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < N; i++) begin
                if (last_gnt[d][i]) busy[d][i] = 1'b0;
                if (!busy[d][i]) begin
                    ren[d][i]  = 1'b0;
                    wren[d][i] = 1'b0;
                    if ($urandom_range(3, 0) != 0) begin
                        kind                 = $urandom_range(3, 0);
                        busy[d][i]           = 1'b1;
                        ren[d][i]            = (kind != 2);
                        wren[d][i]           = (kind >= 2);
                        addr[d][i*AW +: AW]  = AW'($urandom);
                        wdata[d][i*DW +: DW] = DW'($urandom);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        model_clear();
        for (int d = 0; d < ND; d++) for (int i = 0; i < N; i++) busy[d][i] = 1'b0;

        // Reset state, with a request pending to show grants stay low.
        @(negedge clk);
        set_all(REQ_CPU, 1'b1, 1'b0, 16'h0001, 16'h0000);
        check_cycle();
        @(negedge clk);
        idle_all();
        check_cycle();
        rst_n = 1'b1;

        // Single uncontested read from the VGA requester.
        @(negedge clk);
        idle_all();
        set_all(REQ_VGA, 1'b1, 1'b0, 16'h0040, 16'h0000);
        check_cycle();
        check("t1_gnt", 64'(gnt[0]), 64'(3'b010));
        @(negedge clk);
        idle_all();
        check_cycle();
        check("t1_vld", 64'(rd_valid[0]), 64'(3'b010));
        check("t1_data", 64'(rd_data[0]), 64'(16'hBEEF));

        // Two requesters contend in fixed mode: the loser is forced in on cycle 8.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            idle_all();
            set_all(0, 1'b1, 1'b0, 16'h0100, 16'h0000);
            set_all(1, 1'b1, 1'b0, 16'h0200, 16'h0000);
            check_cycle();
            check($sformatf("t2_gnt_c%0d", c), 64'(gnt[0]), 64'((c == 8) ? 3'b010 : 3'b001));
        end
        @(negedge clk);
        idle_all();
        check_cycle();

        // Read in flight on the latency-2 instance, then a one-cycle reset.
        @(negedge clk);
        idle_all();
        set_all(0, 1'b1, 1'b0, 16'h0300, 16'h0000);
        check_cycle();
        check("t6_gnt", 64'(gnt[2]), 64'(3'b001));
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) set_all(i, 1'b1, 1'b0, 16'(16'h0310 + i), 16'h0000);
        check_cycle();
        check("t6_gnt_rst", 64'(gnt[2]), 64'(0));
        check("t6_vld_rst", 64'(rd_valid[2]), 64'(0));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rst_n = 1'b1;
            idle_all();
            check_cycle();
            check($sformatf("t6_vld_after%0d", c), 64'(rd_valid[2]), 64'(0));
        end

        // Round-robin with everyone requesting; pointer starts from 0 after reset.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            idle_all();
            for (int i = 0; i < N; i++) set_all(i, 1'b0, 1'b1, 16'(16'h0500 + i), 16'(16'hA000 + c));
            check_cycle();
            check($sformatf("t3_gnt_c%0d", c), 64'(gnt[1]), 64'(3'b001 << (c % 3)));
        end

        // Back-to-back reads 0, 2, 1 on the latency-3 instance.
        @(negedge clk);
        idle_all();
        set_all(0, 1'b1, 1'b0, 16'h0400, 16'h0000);
        check_cycle();
        @(negedge clk);
        idle_all();
        set_all(2, 1'b1, 1'b0, 16'h0402, 16'h0000);
        check_cycle();
        @(negedge clk);
        idle_all();
        set_all(1, 1'b1, 1'b0, 16'h0401, 16'h0000);
        check_cycle();
        for (int c = 3; c < 6; c++) begin
            @(negedge clk);
            idle_all();
            check_cycle();
            check($sformatf("t4_vld_c%0d", c), 64'(rd_valid[1]),
                  64'((c == 3) ? 3'b001 : ((c == 4) ? 3'b100 : 3'b010)));
            check($sformatf("t4_data_c%0d", c), 64'(rd_data[1]),
                  64'(ram_val((c == 3) ? 16'h0400 : ((c == 4) ? 16'h0402 : 16'h0401))));
        end

        // ren and wren together is a write.
        @(negedge clk);
        idle_all();
        set_all(2, 1'b1, 1'b1, 16'h0010, 16'h1234);
        check_cycle();
        check("t5_wren", 64'(ram_wren[0]), 64'(1));
        check("t5_rden", 64'(ram_rden[0]), 64'(0));
        check("t5_data", 64'(ram_data[0]), 64'(16'h1234));
        check("t5_addr", 64'(ram_addr[0]), 64'(16'h0010));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle_all();
            check_cycle();
            check($sformatf("t5_novld%0d", c), 64'(rd_valid[1] | rd_valid[0] | rd_valid[2]), 64'(0));
        end

        // Random traffic with occasional resets.
        for (int d = 0; d < ND; d++) last_gnt[d] = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(199, 0) != 0);
            gen_random();
            check_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
